// File: rtl/alu_match_pkg.sv
// ---------------------------------------------------------------------------
// alu_match_pkg
// Shared definitions for the bit-pattern search unit (alu_match_seq) and its
// lane comparator (match_lane_cmp):
//   - result mode encodings (FIRST / LAST / COUNT / BITMAP)
//   - controller state type
//   - NOT_FOUND all-ones result constant
//   - width helpers so the top and the comparator size their buses the same way
// ---------------------------------------------------------------------------
package alu_match_pkg;

  localparam logic [1:0] MATCH_FIRST  = 2'b00;
  localparam logic [1:0] MATCH_LAST   = 2'b01;
  localparam logic [1:0] MATCH_COUNT  = 2'b10;
  localparam logic [1:0] MATCH_BITMAP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sliced down to DATA_W by the user; supports DATA_W up to 64.
  localparam logic [63:0] NOT_FOUND = '1;

  // Index of a lane inside one group; at least one bit even for LANES=1.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Number of hits in one group, 0..LANES.
  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Offset register: must hold pos + LANES without wrapping.
  function automatic int pos_w(input int data_w, input int pat_w, input int lanes);
    return $clog2((data_w - pat_w + 1) + lanes + 1);
  endfunction

endpackage

// File: rtl/match_lane_cmp.sv
// ---------------------------------------------------------------------------
// match_lane_cmp
// Combinational comparator for one group of LANES consecutive bit offsets,
// starting at base_i. Lanes whose offset lies past the last legal offset
// (NPOS-1) never report a hit.
// Ports:
//   data_i  [DATA_W]  searched word
//   pat_i   [PAT_W]   pattern
//   base_i  [POS_W]   offset of lane 0
//   hit_o   [LANES]   per-lane match flags
//   any_o             at least one lane matched
//   lo_o / hi_o       lowest / highest matching lane index (0 when none)
//   cnt_o             number of matching lanes
// ---------------------------------------------------------------------------
module match_lane_cmp
  import alu_match_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8,
  parameter int LANES  = 1,
  parameter int POS_W  = pos_w(DATA_W, PAT_W, LANES)
) (
  input  logic [DATA_W-1:0]              data_i,
  input  logic [PAT_W-1:0]               pat_i,
  input  logic [POS_W-1:0]               base_i,
  output logic [LANES-1:0]               hit_o,
  output logic                           any_o,
  output logic [lane_idx_w(LANES)-1:0]   lo_o,
  output logic [lane_idx_w(LANES)-1:0]   hi_o,
  output logic [lane_cnt_w(LANES)-1:0]   cnt_o
);
  localparam int NPOS   = DATA_W - PAT_W + 1;
  localparam int LIDX_W = lane_idx_w(LANES);
  localparam int PCNT_W = lane_cnt_w(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [POS_W-1:0] lane_pos;
    assign lane_pos  = base_i + POS_W'(gi);
    assign hit_o[gi] = (lane_pos < POS_W'(NPOS)) &&
                       (PAT_W'(data_i >> lane_pos) == pat_i);
  end

  assign any_o = |hit_o;

  always_comb begin
    lo_o  = '0;
    hi_o  = '0;
    cnt_o = '0;
    // Descending walk so the lowest hit is written last.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hit_o[l]) lo_o = LIDX_W'(l);
    end
    for (int l = 0; l < LANES; l++) begin
      if (hit_o[l]) begin
        hi_o  = LIDX_W'(l);
        cnt_o = cnt_o + PCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_match_seq.sv
// ---------------------------------------------------------------------------
// alu_match_seq
// Multi-cycle bit-pattern search beside the ALU. Finds src1[PAT_W-1:0] in src2
// at every bit offset, LANES offsets per SCAN cycle, and reports the first
// index, last index, match count or match bitmap.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready == IDLE)
//   mode, src1, src2    operation, sampled on accept
//   flush               abort any operation, back to IDLE next cycle
//   out_valid/out_ready result handshake (out_valid == DONE)
//   result, found       registered result, updated on entering DONE
//   busy                stall request, high in SCAN and DONE
// ---------------------------------------------------------------------------
module alu_match_seq
  import alu_match_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              found,
  output logic              busy
);
  localparam int NPOS   = DATA_W - PAT_W + 1;
  localparam int POS_W  = pos_w(DATA_W, PAT_W, LANES);
  localparam int CNT_W  = $clog2(NPOS + 1);
  localparam int LIDX_W = lane_idx_w(LANES);
  localparam int PCNT_W = lane_cnt_w(LANES);

  state_t            state_q,  state_d;
  logic [1:0]        mode_q,   mode_d;
  logic [PAT_W-1:0]  pat_q,    pat_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [POS_W-1:0]  pos_q,    pos_d;
  logic [POS_W-1:0]  first_q,  first_d;
  logic [POS_W-1:0]  last_q,   last_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] bitmap_q, bitmap_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              found_q,  found_d;

  logic [LANES-1:0]  lane_hit;
  logic              lane_any;
  logic [LIDX_W-1:0] lane_lo;
  logic [LIDX_W-1:0] lane_hi;
  logic [PCNT_W-1:0] lane_cnt;
  logic [DATA_W-1:0] hit_ext;
  logic              scan_last;

  // Only the low PAT_W bits of src1 carry the pattern.
  logic src1_unused;
  assign src1_unused = ^src1;

  match_lane_cmp #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .LANES  (LANES),
    .POS_W  (POS_W)
  ) u_cmp (
    .data_i (data_q),
    .pat_i  (pat_q),
    .base_i (pos_q),
    .hit_o  (lane_hit),
    .any_o  (lane_any),
    .lo_o   (lane_lo),
    .hi_o   (lane_hi),
    .cnt_o  (lane_cnt)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    data_d   = data_q;
    pos_d    = pos_q;
    first_d  = first_q;
    last_d   = last_q;
    count_d  = count_q;
    bitmap_d = bitmap_q;
    result_d = result_q;
    found_d  = found_q;

    hit_ext = '0;
    hit_ext[LANES-1:0] = lane_hit;
    // This group reaches the last legal offset.
    scan_last = (pos_q + POS_W'(LANES)) >= POS_W'(NPOS);

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          mode_d   = mode;
          pat_d    = src1[PAT_W-1:0];
          data_d   = src2;
          pos_d    = '0;
          first_d  = '0;
          last_d   = '0;
          count_d  = '0;
          bitmap_d = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        count_d  = count_q + CNT_W'(lane_cnt);
        bitmap_d = bitmap_q | (hit_ext << pos_q);
        if (lane_any) begin
          // An earlier group already owns "first" once count is non-zero.
          if (count_q == '0) first_d = pos_q + POS_W'(lane_lo);
          last_d = pos_q + POS_W'(lane_hi);
        end
        pos_d = pos_q + POS_W'(LANES);
        if (((mode_q == MATCH_FIRST) && lane_any) || scan_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;

    // Result registers move only on the SCAN->DONE transition.
    if ((state_q == SCAN) && (state_d == DONE)) begin
      found_d = (count_d != '0);
      case (mode_q)
        MATCH_FIRST:  result_d = found_d ? DATA_W'(first_d) : NOT_FOUND[DATA_W-1:0];
        MATCH_LAST:   result_d = found_d ? DATA_W'(last_d)  : NOT_FOUND[DATA_W-1:0];
        MATCH_COUNT:  result_d = DATA_W'(count_d);
        default:      result_d = bitmap_d;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MATCH_FIRST;
      pat_q    <= '0;
      data_q   <= '0;
      pos_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      count_q  <= '0;
      bitmap_q <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      data_q   <= data_d;
      pos_q    <= pos_d;
      first_q  <= first_d;
      last_q   <= last_d;
      count_q  <= count_d;
      bitmap_q <= bitmap_d;
      result_q <= result_d;
      found_q  <= found_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign found     = found_q;

endmodule

// File: tb/tb_alu_match_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_match_seq
// Directed bench for alu_match_seq. Two instances share all inputs: dut0 at
// LANES=1 and dut1 at LANES=4, so each vector checks both latencies.
// ---------------------------------------------------------------------------
module tb_alu_match_seq;

  localparam logic [1:0] M_FIRST  = 2'b00;
  localparam logic [1:0] M_LAST   = 2'b01;
  localparam logic [1:0] M_COUNT  = 2'b10;
  localparam logic [1:0] M_BITMAP = 2'b11;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, out_valid0, found0, busy0;
  logic [31:0] result0;
  logic        in_ready1, out_valid1, found1, busy1;
  logic [31:0] result1;

  int n_checks = 0;
  int n_bad    = 0;

  alu_match_seq #(.DATA_W(32), .PAT_W(8), .LANES(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .mode      (mode),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .found     (found0),
    .busy      (busy0)
  );

  alu_match_seq #(.DATA_W(32), .PAT_W(8), .LANES(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .mode      (mode),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (result1),
    .found     (found1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge with both units idle. Issues one op,
  // records the first out_valid cycle (1 = the cycle right after accept) of
  // each instance, checks it, then lets the DONE handshake complete.
  task automatic run_op(input string tag, input logic [1:0] m,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] exp_res, input logic exp_fnd,
                        input int exp_lat0, input int exp_lat1);
    int n;
    logic g0, g1, f0, f1;
    logic [31:0] r0, r1;
    int l0, l1;
    g0 = 1'b0; g1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
    r0 = '0;   r1 = '0;   l0 = 0;    l1 = 0;
    check_val({tag, "_in_ready0"}, 32'(in_ready0), 32'd1);
    check_val({tag, "_in_ready1"}, 32'(in_ready1), 32'd1);
    in_valid = 1'b1; mode = m; src1 = s1; src2 = s2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(g0 && g1) && n < 100) begin
      n++;
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (!g0 && out_valid0) begin g0 = 1'b1; l0 = n; r0 = result0; f0 = found0; end
      if (!g1 && out_valid1) begin g1 = 1'b1; l1 = n; r1 = result1; f1 = found1; end
    end
    check_val({tag, "_res0"},   r0,        exp_res);
    check_val({tag, "_found0"}, 32'(f0),   32'(exp_fnd));
    check_val({tag, "_lat0"},   32'(l0),   32'(exp_lat0));
    check_val({tag, "_res1"},   r1,        exp_res);
    check_val({tag, "_found1"}, 32'(f1),   32'(exp_fnd));
    check_val({tag, "_lat1"},   32'(l1),   32'(exp_lat1));
    $display("op %s mode=%0d src1=%h src2=%h res0=%h lat0=%0d res1=%h lat1=%0d",
             tag, m, s1, s2, r0, l0, r1, l1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; in_valid = 1'b0; mode = M_FIRST; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check_val("rst_in_ready",  32'(in_ready0),  32'd1);
    check_val("rst_out_valid", 32'(out_valid0), 32'd0);
    check_val("rst_busy",      32'(busy0),      32'd0);
    check_val("rst_found",     32'(found0),     32'd0);
    check_val("rst_result",    result0,         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Main function, directed vectors
    run_op("first_a5",   M_FIRST,  32'h000000A5, 32'h0000A500, 32'd8,        1'b1, 10, 4);
    run_op("last_a5",    M_LAST,   32'h000000A5, 32'h0000A500, 32'd8,        1'b1, 26, 8);
    run_op("count_zero", M_COUNT,  32'h00000000, 32'h00000000, 32'd25,       1'b1, 26, 8);
    run_op("bmap_zero",  M_BITMAP, 32'h00000000, 32'h00000000, 32'h01FFFFFF, 1'b1, 26, 8);
    run_op("first_zero", M_FIRST,  32'h00000000, 32'h00000000, 32'd0,        1'b1, 2,  2);
    run_op("first_none", M_FIRST,  32'h000000FF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 26, 8);
    run_op("last_none",  M_LAST,   32'h000000FF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 26, 8);
    run_op("count_none", M_COUNT,  32'h000000FF, 32'h00000000, 32'd0,        1'b0, 26, 8);
    // Pattern 0x01 in 0x01000101 matches at offsets 0, 8 and 24 (last legal)
    run_op("last_3hit",  M_LAST,   32'hFFFFFF01, 32'h01000101, 32'd24,       1'b1, 26, 8);
    run_op("count_3hit", M_COUNT,  32'h00000001, 32'h01000101, 32'd3,        1'b1, 26, 8);
    run_op("bmap_3hit",  M_BITMAP, 32'h00000001, 32'h01000101, 32'h01000101, 1'b1, 26, 8);
    run_op("first_top",  M_FIRST,  32'h00000001, 32'h01000000, 32'd24,       1'b1, 26, 8);

    // Back-pressure: hold DONE for three cycles
    out_ready = 1'b0;
    in_valid = 1'b1; mode = M_COUNT; src1 = '0; src2 = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("bp_lat", 32'(n), 32'd26);
    for (int k = 0; k < 3; k++) begin
      check_val("bp_valid",    32'(out_valid0), 32'd1);
      check_val("bp_result",   result0,         32'd25);
      check_val("bp_found",    32'(found0),     32'd1);
      check_val("bp_busy",     32'(busy0),      32'd1);
      check_val("bp_in_ready", 32'(in_ready0),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_val("bp_hs_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    check_val("bp_rel_in_ready",  32'(in_ready0),  32'd1);
    check_val("bp_rel_out_valid", 32'(out_valid0), 32'd0);
    check_val("bp_rel_in_ready1", 32'(in_ready1),  32'd1);
    $display("op backpressure lat0=%0d", n);

    // Flush on the fifth SCAN cycle, then an immediate new op
    in_valid = 1'b1; mode = M_FIRST; src1 = 32'hFF; src2 = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("fl_in_ready",  32'(in_ready0),  32'd1);
    check_val("fl_out_valid", 32'(out_valid0), 32'd0);
    check_val("fl_busy",      32'(busy0),      32'd0);
    check_val("fl_result",    result0,         32'd25);
    $display("op flush at scan cycle 5");
    run_op("after_flush", M_LAST, 32'h00000001, 32'h01000101, 32'd24, 1'b1, 26, 8);

    // Asynchronous reset in the middle of SCAN, off the clock edge
    in_valid = 1'b1; mode = M_COUNT; src1 = '0; src2 = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("ar_in_ready",  32'(in_ready0),  32'd1);
    check_val("ar_out_valid", 32'(out_valid0), 32'd0);
    check_val("ar_busy",      32'(busy0),      32'd0);
    check_val("ar_found",     32'(found0),     32'd0);
    check_val("ar_result",    result0,         32'd0);
    #2;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen++;
    end
    check_val("ar_no_stale_valid", 32'(seen), 32'd0);
    $display("op async reset mid-scan stale_valid=%0d", seen);
    run_op("after_rst", M_BITMAP, 32'h000000A5, 32'h0000A500, 32'h00000100, 1'b1, 26, 8);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
